// File: rtl/misc_v_pkg.sv
// rtl/misc_v_pkg.sv - ALU opcode constants and issue controller state encoding
package misc_v_pkg;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_OR  = 3'd2;
  localparam logic [2:0] ALU_AND = 3'd3;
  localparam logic [2:0] ALU_SHL = 3'd4;
  localparam logic [2:0] ALU_SHR = 3'd5;
  localparam logic [2:0] ALU_XOR = 3'd6;
  localparam logic [2:0] ALU_CLR = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    CAPT = 2'd2
  } state_t;

endpackage

// File: rtl/alu_rsp_fifo.sv
// rtl/alu_rsp_fifo.sv - synchronous response FIFO with flush and registered occupancy count
module alu_rsp_fifo #(
  parameter int W     = 21,
  parameter int DEPTH = 2
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     flush,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else if (flush) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

  always_ff @(posedge CLK) begin
    if (push && !flush) mem[wp] <= wdata;
  end

  assign rdata = mem[rp];
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - single-op-in-flight issue controller for the registered ALU
module alu_issue_ctrl
  import misc_v_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int TAG_W     = 4,
  parameter int ALU_LAT   = 1,
  parameter int RSP_DEPTH = 2
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              flush,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  input  logic [TAG_W-1:0]  req_tag,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_op,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_zero,
  output logic [TAG_W-1:0]  rsp_tag
);

  localparam int FW = DATA_W + 1 + TAG_W;
  localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam int AW = $clog2(RSP_DEPTH);

  state_t           state;
  state_t           state_nxt;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_nxt;
  logic [TAG_W-1:0] tag_q;

  logic             accept;
  logic             push;
  logic             pop;
  logic             full;
  logic             empty;
  logic [AW:0]      count;
  logic [FW-1:0]    rdata;

  assign rsp_valid = (count != '0);
  assign pop       = rsp_valid && rsp_ready;
  // A same-cycle pop frees a slot, so a full FIFO being drained still accepts.
  assign req_ready = RST_N && (state == IDLE) && !flush && (!full || pop);
  assign accept    = req_valid && req_ready;
  assign push      = (state == CAPT) && !flush;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = WAIT;
          cnt_nxt   = '0;
        end
      end
      WAIT: begin
        if (cnt == CW'(ALU_LAT - 1)) state_nxt = CAPT;
        else                         cnt_nxt   = cnt + 1'b1;
      end
      CAPT:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end
  end

  // Operands and tag stay registered until the next accept; flush leaves them alone.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state  <= IDLE;
      cnt    <= '0;
      alu_a  <= '0;
      alu_b  <= '0;
      alu_op <= ALU_CLR;
      tag_q  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        alu_a  <= req_a;
        alu_b  <= req_b;
        alu_op <= req_op;
        tag_q  <= req_tag;
      end
    end
  end

  alu_rsp_fifo #(
    .W     (FW),
    .DEPTH (RSP_DEPTH)
  ) u_fifo (
    .CLK   (CLK),
    .RST_N (RST_N),
    .flush (flush),
    .push  (push),
    .wdata ({alu_result, alu_zero, tag_q}),
    .pop   (pop),
    .rdata (rdata),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign {rsp_result, rsp_zero, rsp_tag} = empty ? '0 : rdata;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - scoreboard bench for alu_issue_ctrl with behavioural ALU
module tb_alu_issue_ctrl;

  localparam int DW  = 16;
  localparam int TW  = 4;
  localparam int LAT = 1;
  localparam int DEP = 2;

  logic          CLK = 1'b0;
  logic          RST_N;
  logic          flush;
  logic          req_valid;
  logic          req_ready;
  logic [2:0]    req_op;
  logic [DW-1:0] req_a;
  logic [DW-1:0] req_b;
  logic [TW-1:0] req_tag;
  logic [DW-1:0] alu_a;
  logic [DW-1:0] alu_b;
  logic [2:0]    alu_op;
  logic [DW-1:0] alu_result;
  logic          alu_zero;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_result;
  logic          rsp_zero;
  logic [TW-1:0] rsp_tag;

  int n_vec = 0;
  int n_err = 0;
  logic [DW+TW:0] expq[$];
  logic           hold_prev = 1'b0;
  logic [DW+TW:0] prev_rsp;
  logic           bg_done;

  alu_issue_ctrl #(.DATA_W(DW), .TAG_W(TW), .ALU_LAT(LAT), .RSP_DEPTH(DEP)) dut (
    .CLK(CLK), .RST_N(RST_N), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_tag(rsp_tag)
  );

  always #5 CLK = ~CLK;

  function automatic logic [DW-1:0] alu_f(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a | b;
      3'd3: return a & b;
      3'd4: return a << b[3:0];
      3'd5: return a >> b[3:0];
      3'd6: return a ^ b;
      default: return '0;
    endcase
  endfunction

  function automatic logic [DW+TW:0] ref_rsp(input logic [2:0] op, input logic [DW-1:0] a,
                                             input logic [DW-1:0] b, input logic [TW-1:0] tag);
    logic [DW-1:0] r;
    r = alu_f(op, a, b);
    return {r, (r == 0), tag};
  endfunction

  // Behavioural registered ALU: result appears LAT cycles after operands settle.
  logic [DW:0] pipe [LAT];
  always @(posedge CLK) begin
    pipe[0] <= {alu_f(alu_op, alu_a, alu_b), (alu_f(alu_op, alu_a, alu_b) == 0)};
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign alu_result = pipe[LAT-1][DW:1];
  assign alu_zero   = pipe[LAT-1][0];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: samples mid-cycle, pops on response handshake, pushes on request accept.
  always begin
    @(negedge CLK);
    #3;
    if (!RST_N) begin
      expq.delete();
      hold_prev = 1'b0;
      chk("rst_outs", {req_ready, rsp_valid, alu_op, rsp_result, rsp_zero, rsp_tag}, {2'b00, 3'd7, 21'd0});
      chk("rst_alu", {alu_a, alu_b}, 32'd0);
    end else begin
      if (hold_prev) chk("rsp_stable", {rsp_valid, rsp_result, rsp_zero, rsp_tag}, {1'b1, prev_rsp});
      n_vec++;
      if (dut.push && dut.u_fifo.full) begin
        n_err++;
        $display("FAIL push_when_full: push=1 full=1 at %0t", $time);
      end
      if (flush) chk("flush_no_ready", req_ready, 0);
      if (rsp_valid && rsp_ready) begin
        if (expq.size() == 0) chk("rsp_unexpected", 1, 0);
        else chk("rsp", {rsp_result, rsp_zero, rsp_tag}, expq.pop_front());
      end
      if (flush) expq.delete();
      else if (req_valid && req_ready) expq.push_back(ref_rsp(req_op, req_a, req_b, req_tag));
      hold_prev = rsp_valid && !rsp_ready && !flush;
      prev_rsp  = {rsp_result, rsp_zero, rsp_tag};
    end
  end

  // Call just after a negedge; returns at the negedge following the accepting edge.
  task automatic issue(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [TW-1:0] tag);
    int t = 0;
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_tag = tag;
    forever begin
      #3;
      if (req_ready || t > 200) break;
      @(negedge CLK);
      t++;
    end
    chk("issue_timeout", (t > 200), 0);
    @(negedge CLK);
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input logic [DW-1:0] res, input logic z, input logic [TW-1:0] tag);
    int t = 0;
    forever begin
      #3;
      if (rsp_valid || t > 50) break;
      @(negedge CLK);
      t++;
    end
    chk("rsp_timeout", (t > 50), 0);
    chk("rsp_fields", {rsp_result, rsp_zero, rsp_tag}, {res, z, tag});
    @(negedge CLK);
  endtask

  initial begin
    int lat;
    RST_N = 1'b0; flush = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    req_op = '0; req_a = '0; req_b = '0; req_tag = '0; bg_done = 1'b0;
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);

    // ADD with latency measured from the accept cycle
    rsp_ready = 1'b1;
    issue(3'd0, 16'd3, 16'd5, 4'd1);
    lat = 1;
    forever begin
      #3;
      if (rsp_valid || lat > 20) break;
      @(negedge CLK);
      lat++;
    end
    chk("latency", lat, LAT + 2);
    chk("add_fields", {rsp_result, rsp_zero, rsp_tag}, {16'd8, 1'b0, 4'd1});
    @(negedge CLK);

    issue(3'd1, 16'h1234, 16'h1234, 4'd2);
    wait_rsp(16'h0000, 1'b1, 4'd2);
    issue(3'd4, 16'h0001, 16'h0004, 4'd3);
    wait_rsp(16'h0010, 1'b0, 4'd3);

    // Back-pressure: two buffered, third held until a pop frees a slot
    rsp_ready = 1'b0;
    issue(3'd2, 16'h00F0, 16'h000F, 4'd1);
    issue(3'd6, 16'hAAAA, 16'h5555, 4'd2);
    req_valid = 1'b1; req_op = 3'd3; req_a = 16'hFF00; req_b = 16'h0FF0; req_tag = 4'd3;
    repeat (8) begin
      #3;
      chk("full_ready_low", req_ready, 0);
      @(negedge CLK);
    end
    rsp_ready = 1'b1;
    #3;
    chk("accept_on_pop", {rsp_valid, req_ready}, 2'b11);
    @(negedge CLK);
    req_valid = 1'b0;
    repeat (10) @(negedge CLK);
    chk("drain_empty", expq.size(), 0);

    // Flush in WAIT, then in CAPT
    for (int s = 0; s < 2; s++) begin
      issue(3'd0, 16'd7, 16'd9, 4'd5);
      repeat (s * LAT) @(negedge CLK);
      flush = 1'b1;
      @(negedge CLK);
      flush = 1'b0;
      #3;
      chk("flush_ready", {req_ready, rsp_valid}, 2'b10);
      repeat (5) begin
        @(negedge CLK);
        #3;
        chk("flush_no_rsp", rsp_valid, 0);
      end
      @(negedge CLK);
    end

    // Flush with responses buffered
    rsp_ready = 1'b0;
    issue(3'd0, 16'd1, 16'd1, 4'd6);
    issue(3'd0, 16'd2, 16'd2, 4'd7);
    repeat (LAT + 2) @(negedge CLK);
    flush = 1'b1;
    @(negedge CLK);
    flush = 1'b0;
    #3;
    chk("flush_fifo_empty", {rsp_valid, rsp_result, rsp_tag}, 21'd0);
    @(negedge CLK);
    rsp_ready = 1'b1;

    // Async reset during WAIT
    issue(3'd0, 16'd4, 16'd4, 4'd8);
    #2;
    RST_N = 1'b0;
    #1;
    chk("async_rst", {req_ready, rsp_valid, alu_op, alu_a, alu_b}, {2'b00, 3'd7, 32'd0});
    @(negedge CLK);
    RST_N = 1'b1;
    repeat (5) begin
      @(negedge CLK);
      #3;
      chk("rst_no_stale", rsp_valid, 0);
    end
    @(negedge CLK);
    issue(3'd0, 16'hFFFF, 16'h0001, 4'd9);
    wait_rsp(16'h0000, 1'b1, 4'd9);

    // Random traffic with random back-pressure and occasional flush
    fork
      begin
        for (int n = 0; n < 150; n++) begin
          logic [DW-1:0] a;
          logic [DW-1:0] b;
          a = DW'($urandom);
          b = ($urandom_range(0, 5) == 0) ? a : DW'($urandom);
          repeat ($urandom_range(0, 2)) @(negedge CLK);
          issue(3'($urandom_range(0, 7)), a, b, TW'($urandom));
        end
        bg_done = 1'b1;
      end
      begin
        while (!bg_done) begin
          @(negedge CLK);
          if ($urandom_range(0, 49) == 0) begin
            flush = 1'b1; rsp_ready = 1'b0;
          end else begin
            flush = 1'b0; rsp_ready = 1'($urandom_range(0, 1));
          end
        end
        flush = 1'b0;
        rsp_ready = 1'b1;
      end
    join
    repeat (20) @(negedge CLK);
    #3;
    chk("final_empty", {31'd0, rsp_valid}, 0);
    chk("final_queue", expq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
